param_stream_sink: RTL and testbench

PARAM_STREAM_SINK -- requirements
Module: param_stream_sink

---
 rtl/param_stream_sink_if.sv | 56 +++++
 rtl/param_stream_sink.sv | 139 +++++++++++++
 tb/tb_param_stream_sink.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/param_stream_sink_if.sv
// param_stream_sink_if
//    Bundles the streaming write side, load status and read port of
//    param_stream_sink into one interface.
//    Optional feature macro: PARAM_SINK_CHECKSUM_EN adds the 32-bit checksum signal.
//
//    Signals:
//       data_in        beat lanes, PARALLELISM_DIM_0 x PRECISION_0
//       data_in_valid  beat present (master -> slave)
//       data_in_ready  sink accepts a beat (slave -> master)
//       restart        single-cycle request to reload the tensor
//       loaded         full tensor stored
//       beat_count     beats accepted in the current load
//       rd_addr        read beat index
//       rd_ce          read clock enable
//       rd_q           packed read data, lane j at [PRECISION_0*j +: PRECISION_0]
//       checksum       (PARAM_SINK_CHECKSUM_EN only) wrap-around sum of counted lanes
//
//    Modports: master drives the stream and the read request; slave is the sink.
interface param_stream_sink_if #(
   parameter int PRECISION_0       = 16,
   parameter int PARALLELISM_DIM_0 = 1,
   parameter int AWIDTH            = 6
);
   logic [PRECISION_0-1:0]                   data_in [PARALLELISM_DIM_0];
   logic                                     data_in_valid;
   logic                                     data_in_ready;
   logic                                     restart;
   logic                                     loaded;
   logic [AWIDTH-1:0]                        beat_count;
   logic [AWIDTH-1:0]                        rd_addr;
   logic                                     rd_ce;
   logic [PRECISION_0*PARALLELISM_DIM_0-1:0] rd_q;
`ifdef PARAM_SINK_CHECKSUM_EN
   logic [31:0]                              checksum;

   modport master (
      output data_in, data_in_valid, restart, rd_addr, rd_ce,
      input  data_in_ready, loaded, beat_count, rd_q, checksum
   );

   modport slave (
      input  data_in, data_in_valid, restart, rd_addr, rd_ce,
      output data_in_ready, loaded, beat_count, rd_q, checksum
   );
`else
   modport master (
      output data_in, data_in_valid, restart, rd_addr, rd_ce,
      input  data_in_ready, loaded, beat_count, rd_q
   );

   modport slave (
      input  data_in, data_in_valid, restart, rd_addr, rd_ce,
      output data_in_ready, loaded, beat_count, rd_q
   );
`endif
endinterface

// File: rtl/param_stream_sink.sv
// param_stream_sink
//    Collects one tensor row, streamed as DEPTH beats of PARALLELISM_DIM_0 lanes,
//    into an inferred block RAM and exposes it through a 2-cycle-latency read port.
//    A two-state FSM (FILL / LOADED) gates the stream; restart reloads the
//    tensor without clearing the RAM.
//    Optional feature macro: PARAM_SINK_CHECKSUM_EN adds bus.checksum, the
//    wrap-around sum of every counted lane of the current load.
//
//    Ports:
//       clk   clock, rising edge
//       rst   synchronous, active-high reset (RAM contents are kept)
//       bus   param_stream_sink_if.slave -- stream input, load status, read port
module param_stream_sink #(
   parameter int  PRECISION_0       = 16,
   parameter int  TENSOR_SIZE_DIM_0 = 32,
   parameter int  PARALLELISM_DIM_0 = 1,
   parameter int  DEPTH             = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
   localparam int AWIDTH            = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   param_stream_sink_if.slave bus
);

   localparam int WORD_W = PRECISION_0 * PARALLELISM_DIM_0;
   // RAM index width; beat_count/rd_addr carry one extra bit so they can hold DEPTH.
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      FILL   = 1'b0,
      LOADED = 1'b1
   } state_t;

   state_t              state_reg, state_next;
   logic [AWIDTH-1:0]   beat_count_reg, beat_count_next;
   logic                data_in_ready;
   logic                wr_en;
   logic                count_en;
   logic [WORD_W-1:0]   wr_word;
   logic [IDX_W-1:0]    wr_idx;
   logic [IDX_W-1:0]    rd_idx;

   logic [WORD_W-1:0]   mem [DEPTH];
   logic [WORD_W-1:0]   rd_s1_reg;
   logic [WORD_W-1:0]   rd_q_reg;

   // Ready is a decode of the state register only, so valid never reaches ready.
   assign data_in_ready = (state_reg == FILL);

   // A beat arriving together with restart still lands in RAM, it just is not
   // counted. Reset wins over everything, including the RAM write.
   assign wr_en    = bus.data_in_valid && data_in_ready && !rst;
   assign count_en = wr_en && !bus.restart;

   assign wr_idx = beat_count_reg[IDX_W-1:0];
   // Out-of-range addresses alias into the array; the result is don't-care.
   assign rd_idx = bus.rd_addr[IDX_W-1:0];

   generate
      for (genvar gi = 0; gi < PARALLELISM_DIM_0; gi++) begin : g_pack
         assign wr_word[gi*PRECISION_0 +: PRECISION_0] = bus.data_in[gi];
      end
   endgenerate

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= FILL;
         beat_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         beat_count_reg <= beat_count_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      beat_count_next = beat_count_reg;
      if (bus.restart) begin
         state_next      = FILL;
         beat_count_next = '0;
      end else if (count_en) begin
         // Last beat parks the counter at DEPTH while LOADED.
         beat_count_next = beat_count_reg + 1'b1;
         if (beat_count_reg == AWIDTH'(DEPTH - 1)) begin
            state_next = LOADED;
         end
      end
   end

   // ---------------------------------------------------------------- RAM
   // Write and read share the edge; the read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_word;
      end
   end

   // Two-stage read pipeline; both stages advance only with rd_ce.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_s1_reg <= '0;
         rd_q_reg  <= '0;
      end else if (bus.rd_ce) begin
         rd_s1_reg <= mem[rd_idx];
         rd_q_reg  <= rd_s1_reg;
      end
   end

   assign bus.data_in_ready = data_in_ready;
   assign bus.loaded        = (state_reg == LOADED);
   assign bus.beat_count    = beat_count_reg;
   assign bus.rd_q          = rd_q_reg;

`ifdef PARAM_SINK_CHECKSUM_EN
   // ---------------------------------------------------------------- checksum
   logic [31:0] checksum_reg;
   logic [31:0] lane_sum;

   always_comb begin
      lane_sum = '0;
      for (int j = 0; j < PARALLELISM_DIM_0; j++) begin
         lane_sum = lane_sum + 32'(bus.data_in[j]);
      end
   end

   // Only counted beats contribute, so the value is naturally frozen in LOADED.
   always_ff @(posedge clk) begin
      if (rst || bus.restart) begin
         checksum_reg <= '0;
      end else if (count_en) begin
         checksum_reg <= checksum_reg + lane_sum;
      end
   end

   assign bus.checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_param_stream_sink.sv
// tb_param_stream_sink
//    Self-checking bench for param_stream_sink. A behavioural model (array of
//    stored beats, beat counter, loaded flag, two-deep read pipeline) is
//    advanced once per clock from the same inputs the DUT sees, and every
//    DUT output is compared against it after each edge. Directed scenarios
//    cover streaming, valid toggling, restart, mid-load reset, read-first
//    collisions and read stalls, followed by a randomized phase.
//    Build with +define+PARAM_SINK_CHECKSUM_EN to also check the checksum.
module tb_param_stream_sink;

   localparam int P     = 16;
   localparam int T     = 32;
   localparam int PAR   = 1;
   localparam int DEPTH = T / PAR;
   localparam int AW    = $clog2(DEPTH) + 1;
   localparam int W     = P * PAR;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   param_stream_sink_if #(.PRECISION_0(P), .PARALLELISM_DIM_0(PAR), .AWIDTH(AW)) sif ();

   param_stream_sink #(
      .PRECISION_0      (P),
      .TENSOR_SIZE_DIM_0(T),
      .PARALLELISM_DIM_0(PAR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(sif)
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference model
   logic [W-1:0] m_mem   [DEPTH];
   bit           m_known [DEPTH];
   int           m_count;
   bit           m_loaded;
   logic [31:0]  m_chk;
   logic [W-1:0] m_s1, m_q;
   bit           s1_k, q_k;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_lanes(input logic [P-1:0] v);
      for (int j = 0; j < PAR; j++) sif.data_in[j] = v;
   endtask

   task automatic set_random_lanes();
      for (int j = 0; j < PAR; j++) sif.data_in[j] = P'($urandom);
   endtask

   // Advance model and DUT by one clock, then compare every output.
   task automatic cycle();
      logic [W-1:0] beat;
      logic [31:0]  lsum;
      bit           acc;
      int           idx;
      lsum = '0;
      for (int j = 0; j < PAR; j++) begin
         beat[j*P +: P] = sif.data_in[j];
         lsum = lsum + 32'(sif.data_in[j]);
      end
      acc = sif.data_in_valid && !m_loaded;
      if (rst) begin
         m_count = 0; m_loaded = 0; m_chk = '0;
         m_s1 = '0; m_q = '0; s1_k = 1; q_k = 1;
      end else begin
         if (sif.rd_ce) begin
            idx  = int'(sif.rd_addr);
            m_q  = m_s1;
            q_k  = s1_k;
            m_s1 = m_mem[idx];
            s1_k = m_known[idx];
         end
         if (acc) begin
            m_mem[m_count]   = beat;
            m_known[m_count] = 1;
         end
         if (sif.restart) begin
            m_count = 0; m_loaded = 0; m_chk = '0;
         end else if (acc) begin
            $display("beat %0d accepted data=%h", m_count, beat);
            m_count++;
            m_chk = m_chk + lsum;
            if (m_count == DEPTH) m_loaded = 1;
         end
      end
      @(posedge clk);
      #1;
      check_val("ready", 64'(sif.data_in_ready), 64'(!m_loaded));
      check_val("loaded", 64'(sif.loaded), 64'(m_loaded));
      check_val("beat_count", 64'(sif.beat_count), 64'(m_count));
      if (q_k) check_val("rd_q", 64'(sif.rd_q), 64'(m_q));
`ifdef PARAM_SINK_CHECKSUM_EN
      check_val("checksum", 64'(sif.checksum), 64'(m_chk));
`endif
   endtask

   task automatic pulse_restart();
      sif.restart = 1'b1;
      cycle();
      sif.restart = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int           ncyc;
      logic [W-1:0] old_val, new_val, hold_q;

      for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
      rst = 1'b1;
      sif.data_in_valid = 1'b0;
      sif.restart       = 1'b0;
      sif.rd_addr       = '0;
      sif.rd_ce         = 1'b0;
      set_lanes('0);
      repeat (2) cycle();
      rst = 1'b0;
      check_val("rst_ready", 64'(sif.data_in_ready), 64'd1);
      check_val("rst_loaded", 64'(sif.loaded), 64'd0);
      check_val("rst_count", 64'(sif.beat_count), 64'd0);
      check_val("rst_rd_q", 64'(sif.rd_q), 64'd0);

      // full stream, valid held high
      sif.data_in_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         set_lanes(P'(i + 1));
         cycle();
      end
      sif.data_in_valid = 1'b0;
      check_val("full_ready", 64'(sif.data_in_ready), 64'd0);
      check_val("full_loaded", 64'(sif.loaded), 64'd1);
      check_val("full_count", 64'(sif.beat_count), 64'd32);
      sif.rd_addr = AW'(5);
      sif.rd_ce   = 1'b1;
      cycle();
      cycle();
      check_val("read_addr5", 64'(sif.rd_q), 64'h0006);
      sif.rd_ce = 1'b0;

      // valid toggling every cycle
      pulse_restart();
      ncyc = 0;
      for (int k = 0; k < 200; k++) begin
         sif.data_in_valid = (k % 2 == 0);
         set_random_lanes();
         cycle();
         if (sif.loaded) begin
            ncyc = k + 1;
            break;
         end
      end
      sif.data_in_valid = 1'b0;
      check_val("toggle_cycles", 64'(ncyc), 64'd63);

      // restart from LOADED, all-ones stream
      pulse_restart();
      sif.data_in_valid = 1'b1;
      set_lanes('1);
      repeat (DEPTH) cycle();
      sif.data_in_valid = 1'b0;
      check_val("reload_loaded", 64'(sif.loaded), 64'd1);
`ifdef PARAM_SINK_CHECKSUM_EN
      check_val("reload_checksum", 64'(sif.checksum), 64'h001FFFE0);
`endif

      // reset after 10 beats keeps RAM contents
      pulse_restart();
      sif.data_in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_random_lanes();
         cycle();
      end
      sif.data_in_valid = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_val("midrst_count", 64'(sif.beat_count), 64'd0);
      check_val("midrst_loaded", 64'(sif.loaded), 64'd0);
      sif.rd_ce = 1'b1;
      for (int a = 0; a < 12; a++) begin
         sif.rd_addr = AW'(a < 10 ? a : 0);
         cycle();
      end
      sif.rd_ce = 1'b0;

      // read-first collision on entry 3
      sif.data_in_valid = 1'b1;
      repeat (3) begin
         set_random_lanes();
         cycle();
      end
      old_val = m_mem[3];
      set_lanes(~old_val[P-1:0]);
      for (int j = 0; j < PAR; j++) new_val[j*P +: P] = ~old_val[P-1:0];
      sif.rd_addr = AW'(3);
      sif.rd_ce   = 1'b1;
      cycle();
      sif.data_in_valid = 1'b0;
      cycle();
      check_val("collide_old", 64'(sif.rd_q), 64'(old_val));
      cycle();
      check_val("collide_new", 64'(sif.rd_q), 64'(new_val));

      // read stall: address changes, rd_ce low for 4 cycles
      sif.rd_addr = AW'(7);
      sif.rd_ce   = 1'b0;
      hold_q      = m_q;
      repeat (4) begin
         cycle();
         check_val("stall_hold", 64'(sif.rd_q), 64'(hold_q));
      end
      sif.rd_ce = 1'b1;
      repeat (2) cycle();

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         sif.data_in_valid = ($urandom_range(0, 1) == 1);
         sif.restart       = ($urandom_range(0, 29) == 0);
         sif.rd_ce         = ($urandom_range(0, 9) < 7);
         sif.rd_addr       = AW'($urandom_range(0, DEPTH - 1));
         set_random_lanes();
         cycle();
      end
      sif.restart = 1'b0;
      sif.data_in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
